// File: rtl/player_input_ctrl.sv
// Player input front end.
// Merges PS/2 key events and the two MiSTer joystick words into the
// registered player1/player2/pause vectors consumed by the game core.
// Each player's coin goes through a small FSM that emits one fixed-width
// credit pulse and then enforces a lockout gap, so a held or bouncing coin
// input yields exactly one credit.
//
// Coin FSM states (one instance per player):
//   state    | meaning
//   ST_IDLE  | armed, coin out 0, waiting for raw coin
//   ST_PULSE | coin out 1, counting down the pulse width
//   ST_HOLD  | pulse done, waiting for raw coin to drop
//   ST_GAP   | lockout after release, raw coin ignored

module player_input_ctrl #(
   parameter int COIN_PULSE = 100000,
   parameter int COIN_GAP   = 100000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [10:0] ps2_key,
   input  logic [10:0] joystick_0,
   input  logic [10:0] joystick_1,
   output logic [9:0]  player1,
   output logic [9:0]  player2,
   output logic        pause
);

   localparam int CNT_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(COIN_GAP - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_HOLD  = 2'd2,
      ST_GAP   = 2'd3
   } coin_state_t;

   // Joystick word to player layout {service,coin,start,b3,b2,b1,right,left,down,up}.
   function automatic logic [9:0] js_map(input logic [10:0] js);
      return {js[10], js[8], js[7], js[6], js[5], js[4], js[0], js[1], js[2], js[3]};
   endfunction

   logic              prev_toggle_q;
   logic              key_event;
   logic [9:0]        key1_q, key1_d;
   logic [9:0]        key2_q, key2_d;
   logic              keyp_q, keyp_d;
   logic [9:0]        raw1, raw2;
   logic [8:0]        p1_q, p2_q;
   logic              pause_q;
   logic [1:0]        raw_coin;
   logic [1:0]        coin_on;
   coin_state_t       st_q [2];
   coin_state_t       st_d [2];
   logic [CNT_W-1:0]  cnt_q [2];
   logic [CNT_W-1:0]  cnt_d [2];

   // The extended-key flag plays no part in matching.
   logic unused_ext;
   assign unused_ext = ps2_key[8];

   assign key_event = ps2_key[10] ^ prev_toggle_q;

   // Scan-code decode: on an event the matching key takes the pressed flag.
   always_comb begin
      key1_d = key1_q;
      key2_d = key2_q;
      keyp_d = keyp_q;
      if (key_event) begin
         case (ps2_key[7:0])
            8'h75: key1_d[0] = ps2_key[9];
            8'h72: key1_d[1] = ps2_key[9];
            8'h6B: key1_d[2] = ps2_key[9];
            8'h74: key1_d[3] = ps2_key[9];
            8'h14: key1_d[4] = ps2_key[9];
            8'h11: key1_d[5] = ps2_key[9];
            8'h29: key1_d[6] = ps2_key[9];
            8'h16: key1_d[7] = ps2_key[9];
            8'h2E: key1_d[8] = ps2_key[9];
            8'h46: key1_d[9] = ps2_key[9];
            8'h2D: key2_d[0] = ps2_key[9];
            8'h2B: key2_d[1] = ps2_key[9];
            8'h23: key2_d[2] = ps2_key[9];
            8'h34: key2_d[3] = ps2_key[9];
            8'h1C: key2_d[4] = ps2_key[9];
            8'h1B: key2_d[5] = ps2_key[9];
            8'h15: key2_d[6] = ps2_key[9];
            8'h1E: key2_d[7] = ps2_key[9];
            8'h36: key2_d[8] = ps2_key[9];
            8'h45: key2_d[9] = ps2_key[9];
            8'h4D: keyp_d    = ps2_key[9];
            default: ;
         endcase
      end
   end

   assign raw1     = key1_q | js_map(joystick_0);
   assign raw2     = key2_q | js_map(joystick_1);
   assign raw_coin = {raw2[8], raw1[8]};

   // Coin FSM next-state and counter logic for both players.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         st_d[i]    = st_q[i];
         cnt_d[i]   = cnt_q[i];
         coin_on[i] = 1'b0;
         case (st_q[i])
            ST_IDLE: begin
               if (raw_coin[i]) begin
                  st_d[i]  = ST_PULSE;
                  cnt_d[i] = PULSE_LOAD;
               end
            end
            ST_PULSE: begin
               coin_on[i] = 1'b1;
               if (cnt_q[i] == '0) st_d[i] = ST_HOLD;
               else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            ST_HOLD: begin
               if (!raw_coin[i]) begin
                  st_d[i]  = ST_GAP;
                  cnt_d[i] = GAP_LOAD;
               end
            end
            ST_GAP: begin
               if (cnt_q[i] == '0) st_d[i] = ST_IDLE;
               else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            default: st_d[i] = ST_IDLE;
         endcase
      end
   end

   // Key state, registered outputs and coin FSM state.
   always_ff @(posedge clock) begin
      if (reset) begin
         prev_toggle_q <= ps2_key[10];
         key1_q        <= '0;
         key2_q        <= '0;
         keyp_q        <= 1'b0;
         p1_q          <= '0;
         p2_q          <= '0;
         pause_q       <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            st_q[i]  <= ST_IDLE;
            cnt_q[i] <= '0;
         end
      end else begin
         prev_toggle_q <= ps2_key[10];
         key1_q        <= key1_d;
         key2_q        <= key2_d;
         keyp_q        <= keyp_d;
         p1_q          <= {raw1[9], raw1[7:0]};
         p2_q          <= {raw2[9], raw2[7:0]};
         pause_q       <= keyp_q | joystick_0[9] | joystick_1[9];
         for (int i = 0; i < 2; i++) begin
            st_q[i]  <= st_d[i];
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign player1 = {p1_q[8], coin_on[0], p1_q[7:0]};
   assign player2 = {p2_q[8], coin_on[1], p2_q[7:0]};
   assign pause   = pause_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl with COIN_PULSE=4, COIN_GAP=3.
module tb_player_input_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [10:0] ps2_key;
   logic [10:0] joystick_0;
   logic [10:0] joystick_1;
   logic [9:0]  player1;
   logic [9:0]  player2;
   logic        pause;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic tog;

   // Key table: code, owner (1=P1, 2=P2, 0=pause, 3=none), output bit.
   localparam logic [7:0] CODES [22] = '{
      8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h16, 8'h2E, 8'h46,
      8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h15, 8'h1E, 8'h36, 8'h45,
      8'h4D, 8'h5A};
   localparam int OWNER [22] = '{1,1,1,1,1,1,1,1,1,1, 2,2,2,2,2,2,2,2,2,2, 0, 3};
   localparam int OBIT  [22] = '{0,1,2,3,4,5,6,7,8,9, 0,1,2,3,4,5,6,7,8,9, 0, 0};

   // Joystick bit -> player bit (coin and pause handled separately).
   localparam int JS_BIT [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 10};
   localparam int PL_BIT [9] = '{3, 2, 1, 0, 4, 5, 6, 7, 9};

   player_input_ctrl #(.COIN_PULSE(4), .COIN_GAP(3)) dut (
      .clock      (clock),
      .reset      (reset),
      .ps2_key    (ps2_key),
      .joystick_0 (joystick_0),
      .joystick_1 (joystick_1),
      .player1    (player1),
      .player2    (player2),
      .pause      (pause)
   );

   always #5 clock = ~clock;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
      tog     = ~tog;
      ps2_key = {tog, pressed, ext, code};
   endtask

   task automatic test_reset();
      tog        = 1'b1;
      ps2_key    = {1'b1, 1'b0, 1'b0, 8'h00};
      joystick_0 = '0;
      joystick_1 = '0;
      reset      = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(1);
      n_checks++;
      if (player1 !== 10'h000) begin n_fail++; $display("FAIL reset_p1: got %h want %h", player1, 10'h000); end
      n_checks++;
      if (player2 !== 10'h000) begin n_fail++; $display("FAIL reset_p2: got %h want %h", player2, 10'h000); end
      n_checks++;
      if (pause !== 1'b0) begin n_fail++; $display("FAIL reset_pause: got %b want 0", pause); end
      // Code and pressed change without a toggle: no event.
      ps2_key = {tog, 1'b1, 1'b0, 8'h75};
      tick(3);
      n_checks++;
      if (player1 !== 10'h000) begin n_fail++; $display("FAIL no_toggle_p1: got %h want %h", player1, 10'h000); end
      ps2_key = {tog, 1'b1, 1'b0, 8'h4D};
      tick(3);
      n_checks++;
      if (pause !== 1'b0) begin n_fail++; $display("FAIL no_toggle_pause: got %b want 0", pause); end
   endtask

   task automatic test_key_latency();
      send_key(1'b1, 1'b0, 8'h75);
      tick(1);
      n_checks++;
      if (player1 !== 10'h000) begin n_fail++; $display("FAIL key_press_n1: got %h want %h", player1, 10'h000); end
      tick(1);
      n_checks++;
      if (player1 !== 10'h001) begin n_fail++; $display("FAIL key_press_n2: got %h want %h", player1, 10'h001); end
      send_key(1'b0, 1'b0, 8'h75);
      tick(1);
      n_checks++;
      if (player1 !== 10'h001) begin n_fail++; $display("FAIL key_release_n1: got %h want %h", player1, 10'h001); end
      tick(1);
      n_checks++;
      if (player1 !== 10'h000) begin n_fail++; $display("FAIL key_release_n2: got %h want %h", player1, 10'h000); end
   endtask

   task automatic test_key_table();
      logic [9:0] e1, e2;
      logic       ep;
      for (int i = 0; i < 22; i++) begin
         e1 = '0;
         e2 = '0;
         ep = 1'b0;
         if (OWNER[i] == 1) e1[OBIT[i]] = 1'b1;
         if (OWNER[i] == 2) e2[OBIT[i]] = 1'b1;
         if (OWNER[i] == 0) ep = 1'b1;
         send_key(1'b1, 1'(i % 2), CODES[i]);
         tick(2);
         n_checks++;
         if (player1 !== e1 || player2 !== e2 || pause !== ep) begin
            n_fail++;
            $display("FAIL key_table code %h: got p1=%h p2=%h pause=%b want p1=%h p2=%h pause=%b",
                     CODES[i], player1, player2, pause, e1, e2, ep);
         end
         send_key(1'b0, 1'b0, CODES[i]);
         tick(8);
         n_checks++;
         if (player1 !== 10'h000 || player2 !== 10'h000 || pause !== 1'b0) begin
            n_fail++;
            $display("FAIL key_table_release code %h: got p1=%h p2=%h pause=%b want all 0",
                     CODES[i], player1, player2, pause);
         end
      end
   endtask

   task automatic test_joystick();
      logic [9:0] e;
      for (int i = 0; i < 9; i++) begin
         e = '0;
         e[PL_BIT[i]] = 1'b1;
         joystick_0 = 11'(1) << JS_BIT[i];
         tick(1);
         n_checks++;
         if (player1 !== e || player2 !== 10'h000) begin
            n_fail++;
            $display("FAIL js0 bit %0d: got p1=%h p2=%h want p1=%h p2=000", JS_BIT[i], player1, player2, e);
         end
         joystick_0 = '0;
         joystick_1 = 11'(1) << JS_BIT[i];
         tick(1);
         n_checks++;
         if (player2 !== e || player1 !== 10'h000) begin
            n_fail++;
            $display("FAIL js1 bit %0d: got p1=%h p2=%h want p1=000 p2=%h", JS_BIT[i], player1, player2, e);
         end
         joystick_1 = '0;
         tick(1);
         n_checks++;
         if (player1 !== 10'h000 || player2 !== 10'h000) begin
            n_fail++;
            $display("FAIL js_clear bit %0d: got p1=%h p2=%h want 000", JS_BIT[i], player1, player2);
         end
      end
   endtask

   task automatic test_coin_key();
      int cnt, first;
      cnt   = 0;
      first = -1;
      send_key(1'b1, 1'b0, 8'h2E);
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         if (player1[8]) begin
            cnt++;
            if (first < 0) first = k;
         end
      end
      n_checks++;
      if (cnt !== 4) begin n_fail++; $display("FAIL coin_hold_width: got %0d want 4", cnt); end
      n_checks++;
      if (first !== 2) begin n_fail++; $display("FAIL coin_hold_start: got %0d want 2", first); end
      send_key(1'b0, 1'b0, 8'h2E);
      cnt   = 0;
      first = -1;
      for (int k = 1; k <= 12; k++) begin
         tick(1);
         if (player1[8]) begin
            cnt++;
            if (first < 0) first = k;
         end
         if (k == 2) send_key(1'b1, 1'b0, 8'h2E);
         if (k == 3) send_key(1'b0, 1'b0, 8'h2E);
         if (k == 5) send_key(1'b1, 1'b0, 8'h2E);
      end
      n_checks++;
      if (cnt !== 4) begin n_fail++; $display("FAIL coin_repress_width: got %0d want 4", cnt); end
      n_checks++;
      if (first !== 7) begin n_fail++; $display("FAIL coin_repress_start: got %0d want 7", first); end
      send_key(1'b0, 1'b0, 8'h2E);
      tick(10);
      n_checks++;
      if (player1 !== 10'h000) begin n_fail++; $display("FAIL coin_key_idle: got %h want 000", player1); end
   endtask

   task automatic test_coin_short();
      int cnt;
      cnt = 0;
      joystick_0[8] = 1'b1;
      tick(1);
      joystick_0[8] = 1'b0;
      if (player1[8]) cnt++;
      for (int k = 2; k <= 10; k++) begin
         tick(1);
         if (player1[8]) cnt++;
      end
      n_checks++;
      if (cnt !== 4) begin n_fail++; $display("FAIL coin_short_width: got %0d want 4", cnt); end
   endtask

   task automatic test_coin_both();
      int  cnt, first;
      logic same;
      cnt   = 0;
      first = -1;
      same  = 1'b1;
      joystick_0[8] = 1'b1;
      joystick_1[8] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         if (player1[8] !== player2[8]) same = 1'b0;
         if (player1[8]) begin
            cnt++;
            if (first < 0) first = k;
         end
      end
      n_checks++;
      if (same !== 1'b1) begin n_fail++; $display("FAIL coin_both_sync: got %b want 1", same); end
      n_checks++;
      if (cnt !== 4 || first !== 1) begin
         n_fail++;
         $display("FAIL coin_both_pulse: got width %0d start %0d want width 4 start 1", cnt, first);
      end
      joystick_0[8] = 1'b0;
      joystick_1[8] = 1'b0;
      tick(8);
      // Reset during PULSE.
      joystick_0[8] = 1'b1;
      tick(2);
      n_checks++;
      if (player1[8] !== 1'b1) begin n_fail++; $display("FAIL coin_pre_reset: got %b want 1", player1[8]); end
      reset         = 1'b1;
      joystick_0[8] = 1'b0;
      tick(1);
      n_checks++;
      if (player1 !== 10'h000) begin n_fail++; $display("FAIL coin_reset: got %h want 000", player1); end
      reset = 1'b0;
      cnt   = 0;
      for (int k = 1; k <= 6; k++) begin
         tick(1);
         if (player1[8]) cnt++;
      end
      n_checks++;
      if (cnt !== 0) begin n_fail++; $display("FAIL coin_no_resume: got %0d want 0", cnt); end
   endtask

   task automatic test_pause();
      send_key(1'b1, 1'b0, 8'h4D);
      tick(2);
      n_checks++;
      if (pause !== 1'b1) begin n_fail++; $display("FAIL pause_key_on: got %b want 1", pause); end
      send_key(1'b0, 1'b0, 8'h4D);
      tick(2);
      n_checks++;
      if (pause !== 1'b0) begin n_fail++; $display("FAIL pause_key_off: got %b want 0", pause); end
      joystick_1[9] = 1'b1;
      tick(1);
      n_checks++;
      if (pause !== 1'b1 || player2 !== 10'h000) begin
         n_fail++;
         $display("FAIL pause_js1: got pause=%b p2=%h want 1 000", pause, player2);
      end
      joystick_1[9] = 1'b0;
      joystick_0[9] = 1'b1;
      tick(1);
      n_checks++;
      if (pause !== 1'b1 || player1 !== 10'h000) begin
         n_fail++;
         $display("FAIL pause_js0: got pause=%b p1=%h want 1 000", pause, player1);
      end
      joystick_0[9] = 1'b0;
      tick(1);
      n_checks++;
      if (pause !== 1'b0) begin n_fail++; $display("FAIL pause_js_off: got %b want 0", pause); end
      send_key(1'b1, 1'b1, 8'h1C);
      tick(2);
      n_checks++;
      if (player2 !== 10'h010) begin n_fail++; $display("FAIL ext_1c: got %h want %h", player2, 10'h010); end
      send_key(1'b0, 1'b1, 8'h1C);
      tick(2);
      n_checks++;
      if (player2 !== 10'h000) begin n_fail++; $display("FAIL ext_1c_release: got %h want 000", player2); end
   endtask

   task automatic test_back_to_back();
      send_key(1'b1, 1'b0, 8'h75);
      tick(1);
      send_key(1'b1, 1'b0, 8'h72);
      tick(1);
      n_checks++;
      if (player1 !== 10'h001) begin n_fail++; $display("FAIL b2b_first: got %h want %h", player1, 10'h001); end
      tick(1);
      n_checks++;
      if (player1 !== 10'h003) begin n_fail++; $display("FAIL b2b_both: got %h want %h", player1, 10'h003); end
      send_key(1'b0, 1'b0, 8'h75);
      tick(1);
      send_key(1'b0, 1'b0, 8'h72);
      tick(1);
      n_checks++;
      if (player1 !== 10'h002) begin n_fail++; $display("FAIL b2b_release1: got %h want %h", player1, 10'h002); end
      tick(1);
      n_checks++;
      if (player1 !== 10'h000) begin n_fail++; $display("FAIL b2b_release2: got %h want 000", player1); end
   endtask

   initial begin
      test_reset();
      test_key_latency();
      test_key_table();
      test_joystick();
      test_coin_key();
      test_coin_short();
      test_coin_both();
      test_pause();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
